// File: rtl/potato1_exec_unit.sv
// Potato-1 execution datapath: accumulator, 4-entry register file, a stallable input port,
// and a one-entry output buffer. Decodes one 6-bit command every clock.
module potato1_exec_unit #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        command,
    output logic              zeroflag,
    output logic              iowait,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] acc_dbg
);

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_ST  = 3'b100,
        OP_LD  = 3'b101,
        OP_IN  = 3'b110,
        OP_OUT = 3'b111
    } op_e;

    op_e               op;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              zf_q, zf_d;
    logic              ov_q, ov_d;
    logic [DATA_W-1:0] od_q, od_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] rsel;
    logic              acc_we;
    logic              reg_we;

    assign op       = op_e'(command[5:3]);
    assign rsel     = regs_q[command[1:0]];
    assign zeroflag = zf_q;
    assign out_data = od_q;
    assign out_valid = ov_q;
    assign acc_dbg  = acc_q;

    // Handshakes: an input word transfers on a cycle where in_ready & in_valid; an output word
    // transfers on a cycle where out_valid & out_ready. A stalled IN/OUT raises iowait and retries.
    always_comb begin
        acc_d    = acc_q;
        acc_we   = 1'b0;
        reg_we   = 1'b0;
        od_d     = od_q;
        ov_d     = ov_q & ~out_ready;
        iowait   = 1'b0;
        in_ready = 1'b0;
        case (op)
            OP_NOP: ;
            OP_LDI: begin
                acc_d  = DATA_W'(command[2:0]);
                acc_we = 1'b1;
            end
            OP_ADD: begin
                acc_d  = acc_q + rsel;
                acc_we = 1'b1;
            end
            OP_SUB: begin
                acc_d  = acc_q - rsel;
                acc_we = 1'b1;
            end
            OP_ST:  reg_we = 1'b1;
            OP_LD: begin
                acc_d  = rsel;
                acc_we = 1'b1;
            end
            OP_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d  = in_data;
                    acc_we = 1'b1;
                end else begin
                    iowait = 1'b1;
                end
            end
            OP_OUT: begin
                // A drain in the same cycle frees the slot, so reload without a bubble.
                if (!ov_q || out_ready) begin
                    od_d = acc_q;
                    ov_d = 1'b1;
                end else begin
                    iowait = 1'b1;
                end
            end
        endcase
        zf_d = acc_we ? (acc_d == '0) : zf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            zf_q  <= 1'b1;
            ov_q  <= 1'b0;
            od_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
            zf_q  <= zf_d;
            ov_q  <= ov_d;
            od_q  <= od_d;
            if (reg_we) begin
                regs_q[command[1:0]] <= acc_q;
            end
        end
    end

endmodule

// File: tb/tb_potato1_exec_unit.sv
// Bench for potato1_exec_unit: directed scenarios plus random commands against a reference
// model; output words are scoreboarded through exp_q and checked by a separate monitor.
module tb_potato1_exec_unit;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic [5:0]        command;
  logic              zeroflag;
  logic              iowait;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] acc_dbg;

  potato1_exec_unit #(.DATA_W(DATA_W), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .command(command), .zeroflag(zeroflag), .iowait(iowait),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .acc_dbg(acc_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: architectural state as plain integers
  int m_acc;
  int m_regs [4];
  bit m_zf;
  bit m_ov;
  int m_od;
  bit m_stall;
  logic [5:0] last_cmd;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_zf = 1'b1;
    m_ov = 1'b0;
    m_od = 0;
    m_stall = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_acc(input int v);
    m_acc = v % 256;
    m_zf  = (m_acc == 0);
  endtask

  function automatic logic [5:0] mk(input int op, input int arg);
    logic [5:0] c;
    c = 6'((op << 3) | (arg & 7));
    return c;
  endfunction

  // driver: one full clock cycle, starting at a negedge
  task automatic step(input logic [5:0] cmd, input bit iv, input logic [DATA_W-1:0] idata,
                      input bit ordy);
    int op;
    int r;
    bit e_wait;
    bit e_rdy;
    bit drain;
    command = cmd; in_valid = iv; in_data = idata; out_ready = ordy;
    last_cmd = cmd;
    op = int'(cmd[5:3]);
    r = int'(cmd[1:0]);
    e_wait = 1'b0;
    e_rdy = (op == 6);
    drain = m_ov && ordy;
    case (op)
      1: set_acc(int'(cmd[2:0]));
      2: set_acc(m_acc + m_regs[r]);
      3: set_acc(m_acc + 256 - m_regs[r]);
      4: m_regs[r] = m_acc;
      5: set_acc(m_regs[r]);
      6: if (iv) set_acc(int'(idata)); else e_wait = 1'b1;
      7: begin
        if (!m_ov || ordy) begin
          m_od = m_acc;
          m_ov = 1'b1;
          exp_q.push_back(DATA_W'(m_acc));
        end else begin
          e_wait = 1'b1;
        end
      end
      default: ;
    endcase
    if (op != 7 && drain) m_ov = 1'b0;
    m_stall = e_wait;
    #1;
    chk("iowait", int'(iowait), int'(e_wait));
    chk("in_ready", int'(in_ready), int'(e_rdy));
    @(posedge clk);
    #1;
    chk("acc_dbg", int'(acc_dbg), m_acc);
    chk("zeroflag", int'(zeroflag), int'(m_zf));
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("out_data", int'(out_data), m_od);
    @(negedge clk);
  endtask

  // scoreboard monitor: every output transfer must match the oldest expected word
  initial begin
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_xfer: got 0x%0h expected no transfer at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_xfer: got 0x%0h expected 0x%0h at %0t", out_data, e, $time);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; command = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    last_cmd = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_acc", int'(acc_dbg), 0);
    chk("rst_zf", int'(zeroflag), 1);
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_od", int'(out_data), 0);
    chk("rst_iowait", int'(iowait), 0);
    rst_n = 1'b1;
    repeat (2) step(mk(0, 0), 1'b0, '0, 1'b0);

    // arithmetic and register file
    step(mk(1, 5), 0, '0, 0);
    step(mk(4, 1), 0, '0, 0);
    step(mk(1, 3), 0, '0, 0);
    step(mk(2, 1), 0, '0, 0);
    chk("add_acc", int'(acc_dbg), 8);
    step(mk(3, 1), 0, '0, 0);
    chk("sub_acc", int'(acc_dbg), 3);
    step(mk(1, 0), 0, '0, 0);
    chk("ldi0_zf", int'(zeroflag), 1);
    step(mk(1, 1), 0, '0, 0);
    step(mk(4, 0), 0, '0, 0);
    step(mk(1, 0), 0, '0, 0);
    step(mk(3, 0), 0, '0, 0);
    chk("wrap_acc", int'(acc_dbg), 255);

    // stalled IN then zero input
    repeat (3) step(mk(6, 0), 0, 8'($urandom_range(0, 255)), 0);
    step(mk(6, 0), 1, 8'h00, 0);
    chk("in_zero_zf", int'(zeroflag), 1);

    // OUT with a backpressured sink, then reload on drain
    step(mk(1, 6), 0, '0, 0);
    step(mk(7, 0), 0, '0, 0);
    repeat (2) step(mk(7, 0), 0, '0, 0);
    step(mk(1, 2), 0, '0, 0);
    step(mk(7, 0), 0, '0, 0);
    step(mk(7, 0), 0, '0, 1);
    step(mk(0, 0), 0, '0, 1);

    // random traffic obeying the hold-while-stalled rule
    for (int i = 0; i < 400; i++) begin
      logic [5:0] c;
      c = m_stall ? last_cmd : 6'($urandom_range(0, 63));
      step(c, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // reset during a stalled IN
    step(mk(1, 7), 0, '0, 0);
    step(mk(7, 0), 0, '0, 0);
    step(mk(6, 0), 0, '0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_acc", int'(acc_dbg), 0);
    chk("midrst_zf", int'(zeroflag), 1);
    chk("midrst_ov", int'(out_valid), 0);
    command = mk(0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(0, 0), 0, '0, 0);
    step(mk(5, 2), 0, '0, 0);

    // drain whatever is left and confirm nothing is outstanding
    step(mk(1, 4), 0, '0, 1);
    step(mk(7, 0), 0, '0, 1);
    repeat (3) step(mk(0, 0), 0, '0, 1);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
